// File: rtl/mem_arbiter_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_rr
// Description : N-channel round-robin arbiter between drawing engines and the
//               single frame-buffer RAM port. One grant per cycle over a
//               rts/rtr handshake, registered RAM command, and broadcast read
//               return with a one-hot per-channel transfer-complete strobe.
//               Optional macro ARB_CH0_PRIO_EN: channel 0 (display refresh)
//               gets absolute priority; channels 1..NUM_CH-1 round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter_rr #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                            clk,
  input  logic                            rst_,
  input  logic [NUM_CH-1:0]               eng_rts,
  output logic [NUM_CH-1:0]               eng_rtr,
  input  logic [NUM_CH-1:0]               eng_op,
  input  logic [NUM_CH*ADDR_W-1:0]        eng_addr,
  input  logic [NUM_CH*DATA_W-1:0]        eng_data,
  input  logic [NUM_CH*(DATA_W/8)-1:0]    eng_wben,
  input  logic                            mem_busy,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  output logic [DATA_W/8-1:0]             mem_wben,
  input  logic [DATA_W-1:0]               mem_rdata,
  output logic [DATA_W-1:0]               bcast_data,
  output logic [NUM_CH-1:0]               bcast_xfc
);

  localparam int WBEN_W = DATA_W / 8;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  // Round-robin state
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

  // Grant selection
  logic [NUM_CH-1:0] rr_req;
  logic [CH_W-1:0]   grant_idx;
  logic              grant_found;
  logic              grant_vld;
  logic              xfc;
  logic              grant_op;

  // Command stage
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [WBEN_W-1:0] mem_wben_q, mem_wben_d;

  // Read-return pipeline
  logic              rd_pend_q, rd_pend_d;
  logic [CH_W-1:0]   rd_ch_q, rd_ch_d;
  logic [DATA_W-1:0] bcast_data_q, bcast_data_d;
  logic [NUM_CH-1:0] bcast_xfc_q, bcast_xfc_d;

  // Requests eligible for the round-robin scan (ch0 leaves it when it has priority)
  always_comb begin
    rr_req = eng_rts;
`ifdef ARB_CH0_PRIO_EN
    rr_req[0] = 1'b0;
`endif
  end

  // Scan upward from rr_ptr with wrap; first eligible requester wins
  always_comb begin : p_grant
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (!grant_found && rr_req[idx]) begin
        grant_found = 1'b1;
        grant_idx   = CH_W'(idx);
      end
    end
`ifdef ARB_CH0_PRIO_EN
    if (eng_rts[0]) begin
      grant_found = 1'b1;
      grant_idx   = '0;
    end
`endif
  end

  // Ready is one-hot on the winner; suppressed while RAM is busy or in reset
  always_comb begin
    grant_vld = grant_found & ~mem_busy & rst_;
    eng_rtr   = '0;
    if (grant_vld) eng_rtr[grant_idx] = 1'b1;
    xfc      = |(eng_rts & eng_rtr);
    grant_op = eng_op[grant_idx];
  end

  // Advance the pointer past the channel that just transferred
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfc) begin
`ifdef ARB_CH0_PRIO_EN
      if (grant_idx != '0)
        rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
`else
      rr_ptr_d = (grant_idx == LAST_CH) ? '0 : grant_idx + CH_W'(1);
`endif
    end
  end

  // Build the next RAM command from the granted channel; fields hold when idle
  always_comb begin
    mem_en_d    = xfc;
    mem_we_d    = xfc & grant_op;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wben_d  = mem_wben_q;
    if (xfc) begin
      mem_addr_d  = eng_addr[grant_idx*ADDR_W +: ADDR_W];
      mem_wdata_d = eng_data[grant_idx*DATA_W +: DATA_W];
      mem_wben_d  = grant_op ? eng_wben[grant_idx*WBEN_W +: WBEN_W] : '0;
    end
  end

  // Track the issued read and broadcast its data one cycle after the command
  always_comb begin
    rd_pend_d    = xfc & ~grant_op;
    rd_ch_d      = xfc ? grant_idx : rd_ch_q;
    bcast_data_d = bcast_data_q;
    bcast_xfc_d  = '0;
    if (rd_pend_q) begin
      bcast_data_d         = mem_rdata;
      bcast_xfc_d[rd_ch_q] = 1'b1;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      rr_ptr_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wben_q   <= '0;
      rd_pend_q    <= 1'b0;
      rd_ch_q      <= '0;
      bcast_data_q <= '0;
      bcast_xfc_q  <= '0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wben_q   <= mem_wben_d;
      rd_pend_q    <= rd_pend_d;
      rd_ch_q      <= rd_ch_d;
      bcast_data_q <= bcast_data_d;
      bcast_xfc_q  <= bcast_xfc_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wben   = mem_wben_q;
  assign bcast_data = bcast_data_q;
  assign bcast_xfc  = bcast_xfc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter_rr.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter_rr
// Description : Self-checking bench for mem_arbiter_rr (default parameters).
//               Reference grant model plus command/read-return scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic            clk;
  logic            rst_;
  logic [N-1:0]    eng_rts;
  logic [N-1:0]    eng_rtr;
  logic [N-1:0]    eng_op;
  logic [N*AW-1:0] eng_addr;
  logic [N*DW-1:0] eng_data;
  logic [N*BW-1:0] eng_wben;
  logic            mem_busy;
  logic            mem_en;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [BW-1:0]   mem_wben;
  logic [DW-1:0]   mem_rdata;
  logic [DW-1:0]   bcast_data;
  logic [N-1:0]    bcast_xfc;

  mem_arbiter_rr #(.NUM_CH(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_       (rst_),
    .eng_rts    (eng_rts),
    .eng_rtr    (eng_rtr),
    .eng_op     (eng_op),
    .eng_addr   (eng_addr),
    .eng_data   (eng_data),
    .eng_wben   (eng_wben),
    .mem_busy   (mem_busy),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wben   (mem_wben),
    .mem_rdata  (mem_rdata),
    .bcast_data (bcast_data),
    .bcast_xfc  (bcast_xfc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents as seen by the arbiter: fixed value at 0x1234, hash elsewhere
  function automatic logic [DW-1:0] ram_f(input logic [AW-1:0] a);
    if (a == 16'h1234) return 32'hCAFEF00D;
    return {a ^ 16'hA5C3, ~a};
  endfunction

  assign mem_rdata = ram_f(mem_addr);

  typedef struct {
    int            due;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] wben;
  } cmd_t;

  typedef struct {
    int            due;
    logic [N-1:0]  xfc;
    logic [DW-1:0] data;
  } rd_t;

  cmd_t cmd_q[$];
  rd_t  rd_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int m_ptr = 0;
  int mon_g;
  logic [N-1:0]  exp_rtr;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_wdata;
  logic [BW-1:0] last_wben;
  logic [DW-1:0] last_bc;
  cmd_t c_ent;
  rd_t  r_ent;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference arbitration: scan from pointer, optional ch0 priority
  function automatic int model_grant(input logic [N-1:0] rts, input int ptr);
`ifdef ARB_CH0_PRIO_EN
    if (rts[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int c = (ptr + k) % N;
`ifdef ARB_CH0_PRIO_EN
      if (c == 0) continue;
`endif
      if (rts[c]) return c;
    end
    return -1;
  endfunction

  // Monitor on the falling edge: check grant, command and return, then schedule
  always @(negedge clk) begin
    cyc++;
    if (!rst_) begin
      check("rst_rtr",   64'(eng_rtr),    64'h0);
      check("rst_en",    64'(mem_en),     64'h0);
      check("rst_we",    64'(mem_we),     64'h0);
      check("rst_addr",  64'(mem_addr),   64'h0);
      check("rst_wdata", 64'(mem_wdata),  64'h0);
      check("rst_wben",  64'(mem_wben),   64'h0);
      check("rst_bdata", 64'(bcast_data), 64'h0);
      check("rst_bxfc",  64'(bcast_xfc),  64'h0);
      cmd_q.delete();
      rd_q.delete();
      m_ptr      = 0;
      last_addr  = '0;
      last_wdata = '0;
      last_wben  = '0;
      last_bc    = '0;
    end else begin
      mon_g = mem_busy ? -1 : model_grant(eng_rts, m_ptr);
      exp_rtr = (mon_g >= 0) ? N'(1 << mon_g) : '0;
      check("rtr", 64'(eng_rtr), 64'(exp_rtr));
      check("rtr_onehot", 64'($countones(eng_rtr) <= 1), 64'h1);

      if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
        c_ent = cmd_q.pop_front();
        check("cmd_en",    64'(mem_en),    64'h1);
        check("cmd_we",    64'(mem_we),    64'(c_ent.we));
        check("cmd_addr",  64'(mem_addr),  64'(c_ent.addr));
        check("cmd_wdata", 64'(mem_wdata), 64'(c_ent.data));
        check("cmd_wben",  64'(mem_wben),  64'(c_ent.wben));
        last_addr  = c_ent.addr;
        last_wdata = c_ent.data;
        last_wben  = c_ent.wben;
      end else begin
        check("idle_en",    64'(mem_en),    64'h0);
        check("idle_we",    64'(mem_we),    64'h0);
        check("hold_addr",  64'(mem_addr),  64'(last_addr));
        check("hold_wdata", 64'(mem_wdata), 64'(last_wdata));
        check("hold_wben",  64'(mem_wben),  64'(last_wben));
      end

      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        r_ent = rd_q.pop_front();
        check("rd_xfc",  64'(bcast_xfc),  64'(r_ent.xfc));
        check("rd_data", 64'(bcast_data), 64'(r_ent.data));
        last_bc = r_ent.data;
      end else begin
        check("idle_bxfc",  64'(bcast_xfc),  64'h0);
        check("hold_bdata", 64'(bcast_data), 64'(last_bc));
      end

      if (mon_g >= 0) begin
        c_ent.due  = cyc + 1;
        c_ent.we   = eng_op[mon_g];
        c_ent.addr = eng_addr[mon_g*AW +: AW];
        c_ent.data = eng_data[mon_g*DW +: DW];
        c_ent.wben = eng_op[mon_g] ? eng_wben[mon_g*BW +: BW] : '0;
        cmd_q.push_back(c_ent);
        if (!eng_op[mon_g]) begin
          r_ent.due  = cyc + 2;
          r_ent.xfc  = N'(1 << mon_g);
          r_ent.data = ram_f(c_ent.addr);
          rd_q.push_back(r_ent);
        end
`ifdef ARB_CH0_PRIO_EN
        if (mon_g != 0) m_ptr = (mon_g == N - 1) ? 0 : mon_g + 1;
`else
        m_ptr = (mon_g == N - 1) ? 0 : mon_g + 1;
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int c, input logic rts, input logic op,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [BW-1:0] be);
    eng_rts[c]            = rts;
    eng_op[c]             = op;
    eng_addr[c*AW +: AW]  = a;
    eng_data[c*DW +: DW]  = d;
    eng_wben[c*BW +: BW]  = be;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    repeat (2) tick();
    rst_ = 1'b1;
    tick();
  endtask

  initial begin
    rst_     = 1'b0;
    eng_rts  = '0;
    eng_op   = '0;
    eng_addr = '0;
    eng_data = '0;
    eng_wben = '0;
    mem_busy = 1'b0;
    repeat (3) tick();
    rst_ = 1'b1;
    tick();

    // Single write on ch1
    set_ch(1, 1'b1, 1'b1, 16'h0040, 32'hDEADBEEF, 4'hF);
    tick();
    eng_rts = '0;
    repeat (2) tick();

    // All four channels requesting from a fresh pointer
    do_reset();
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < N; c++)
        set_ch(c, 1'b1, 1'($urandom_range(0, 1)), AW'($urandom), $urandom, BW'($urandom));
      tick();
    end
    eng_rts = '0;
    repeat (3) tick();

    // Ch2 read of 0x1234
    set_ch(2, 1'b1, 1'b0, 16'h1234, 32'h0, 4'hF);
    tick();
    eng_rts = '0;
    repeat (4) tick();

    // RAM busy for three cycles with ch3 waiting
    mem_busy = 1'b1;
    set_ch(3, 1'b1, 1'b1, 16'h0300, 32'h12345678, 4'h5);
    repeat (3) tick();
    mem_busy = 1'b0;
    tick();
    eng_rts = '0;
    repeat (3) tick();

    // Ch0 read followed immediately by reset
    set_ch(0, 1'b1, 1'b0, 16'h0100, 32'h0, 4'h0);
    tick();
    eng_rts = '0;
    rst_    = 1'b0;
    repeat (2) tick();
    rst_ = 1'b1;
    repeat (4) tick();

    // Ch0 and ch1 contending continuously
    set_ch(0, 1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    set_ch(1, 1'b1, 1'b0, 16'h0011, 32'h0, 4'h0);
    repeat (6) tick();
    eng_rts = '0;
    repeat (3) tick();

    // Random traffic with busy stalls and one reset mid-stream
    for (int i = 0; i < 300; i++) begin
      for (int c = 0; c < N; c++)
        set_ch(c, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               AW'($urandom), $urandom, BW'($urandom));
      mem_busy = ($urandom_range(0, 3) == 0);
      rst_     = (i != 150);
      tick();
    end
    rst_     = 1'b1;
    eng_rts  = '0;
    mem_busy = 1'b0;
    repeat (4) tick();

    check("drain_cmd", 64'(cmd_q.size()), 64'h0);
    check("drain_rd",  64'(rd_q.size()),  64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
